window_3x3_generator: RTL and testbench
=======================================

// Module: window_3x3_generator
// PURPOSE
//  Streaming 3x3 neighbourhood former feeding edge_detection (p00..p22 inputs).
//  Accepts one raster-order 8-bit grayscale pixel per cycle and holds the two previous
//  image rows in on-chip line buffers. Emits one full 3x3 window per interior pixel, so
//  border rows and columns produce no window.
//  Replaces the software array walk so that edge detection runs on a live pixel stream.
// PARAMETERS
//  IMG_W   256  pixels per row (>=3)
//  IMG_H   256  rows per frame (>=3)
//  DW      8    pixel width in bits
// PORTS
//  clk        in   1            rising-edge clock; the block's only clock
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            in_pixel is valid this cycle; no backpressure, always accepted
//  in_sof     in   1            qualifies the first pixel of a frame (row 0, col 0); ignored unless in_valid
//  in_pixel   in   DW           raster-order pixel
//  out_valid  out  1            p00..p22, out_x, out_y and out_last are valid
//  p00..p22   out  DW each      window; pRC = row R (0=top), col C (0=left); p11 is the centre
//  out_x      out  $clog2(IMG_W)  centre column, 1..IMG_W-2
//  out_y      out  $clog2(IMG_H)  centre row, 1..IMG_H-2
//  out_last   out  1            last window of the frame; centre = (IMG_W-2, IMG_H-2)
// BEHAVIOUR
//  Reset
//   - All outputs are 0. col/row counters are 0. Window registers are 0.
//   - Line-buffer RAM is not reset; stale data is masked by the valid logic.
//  Counters
//   - col increments on each accepted pixel and wraps IMG_W-1 -> 0.
//   - On that wrap, row increments. row wraps IMG_H-1 -> 0 at end of frame.
//  Start of frame
//   - in_valid & in_sof forces the pixel to be treated as (0,0) regardless of counter state.
//   - A mid-frame sof abandons the partial frame. No window from the old frame is emitted after it.
//  Line buffers
//   - Two DW x IMG_W buffers. lb1 holds row r-2 and lb0 holds row r-1, addressed by col.
//   - On an accepted pixel at column c: read lb1[c] and lb0[c], write lb1[c] <= lb0[c] and lb0[c] <= in_pixel.
//   - Read and write at the same address in the same cycle return the old data.
//  Window shift
//   - On an accepted pixel, columns shift left: pR0 <= pR1, pR1 <= pR2.
//   - New right column: p02 <= lb1[c], p12 <= lb0[c], p22 <= in_pixel.
//  Output valid
//   - out_valid <= accepted & (r >= 2) & (c >= 2).
//   - Registered: the window appears the cycle after the pixel that completes it.
//   - out_x <= c-1, out_y <= r-1.
//   - out_last <= accepted & (r == IMG_H-1) & (c == IMG_W-1).
//   - Row-crossing garbage at c = 0 and c = 1 is never flagged valid.
//  Stalls
//   - in_valid low: counters, line buffers and window hold.
//   - out_valid drops to 0 the next cycle. Window data and coordinates hold their last values.
//  Totals and framing
//   - Exactly (IMG_W-2)*(IMG_H-2) windows per frame.
//   - Back-to-back frames need no idle cycles.
//  Reset mid-frame
//   - Immediate return to the reset state. The next frame must start with in_sof.
// TESTING (bench parameters IMG_W=5, IMG_H=4; pixel value = r*5 + c)
//  1. Full frame, in_valid held high, 20 pixels.
//     -> First out_valid one cycle after pixel 12: p00..p22 = 0,1,2 / 5,6,7 / 10,11,12, out_x=1, out_y=1.
//     -> Exactly 6 windows; last window has p11=13, out_x=3, out_y=2, out_last=1.
//  2. Same frame with random in_valid gaps (~40% idle).
//     -> Identical 6-window sequence; out_valid never asserted on a cycle after an idle input.
//  3. Two back-to-back frames, second frame values +100.
//     -> 12 windows in total. Frame-2 first window has p00=100 and p22=112, with no frame-1 data in it.
//  4. in_sof asserted at pixel 8 of frame 1, then a full frame.
//     -> Only the 6 windows of the new frame are emitted, matching test 1 offsets.
//  5. rst_n pulsed low mid-frame (asynchronous, between clock edges).
//     -> All outputs 0 immediately; a subsequent full frame gives the test 1 result.
//  6. Golden model: 256x256 random image through window_3x3_generator + edge_detection.
//     -> 254*254 edge values equal the per-pixel array-walk reference.

Source files
------------

// File: rtl/window_3x3_generator_if.sv
// Pixel-stream input and 3x3 window output bundle for window_3x3_generator.
// master = stream source / window consumer, slave = the window generator.
interface window_3x3_generator_if #(
    parameter int DW = 8,
    parameter int XW = 8,
    parameter int YW = 8
) ();
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_pixel;
    logic          out_valid;
    logic [DW-1:0] p00, p01, p02;
    logic [DW-1:0] p10, p11, p12;
    logic [DW-1:0] p20, p21, p22;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_last;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  out_valid, p00, p01, p02, p10, p11, p12, p20, p21, p22,
        input  out_x, out_y, out_last
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output out_valid, p00, p01, p02, p10, p11, p12, p20, p21, p22,
        output out_x, out_y, out_last
    );
endinterface

// File: rtl/window_3x3_generator.sv
// Streaming 3x3 neighbourhood former: two row line buffers plus a 3x3 shift window,
// emitting one window per interior pixel of a raster-order frame.
module window_3x3_generator #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int DW    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    window_3x3_generator_if.slave     bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] C_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] R_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic [XW-1:0] col, c, col_nx;
    logic [YW-1:0] row, r, row_nx;
    logic          acc;

    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] w   [3][3];

    logic          ov, ol;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;

    assign acc = bus.in_valid;

    // A valid sof pins the current pixel to (0,0) whatever the counters say.
    always_comb begin
        c      = bus.in_sof ? '0 : col;
        r      = bus.in_sof ? '0 : row;
        col_nx = c + X_ONE;
        row_nx = r;
        if (c == C_LAST) begin
            col_nx = '0;
            row_nx = (r == R_LAST) ? '0 : r + Y_ONE;
        end
    end

    // Line buffers are plain RAM: never reset, stale contents masked by out_valid.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[c] <= lb0[c];
            lb0[c] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            ov  <= 1'b0;
            ol  <= 1'b0;
            ox  <= '0;
            oy  <= '0;
            for (int unsigned i = 0; i < 3; i++)
                for (int unsigned j = 0; j < 3; j++)
                    w[i][j] <= '0;
        end else begin
            ov <= acc && (r >= Y_TWO) && (c >= X_TWO);
            ol <= acc && (r == R_LAST) && (c == C_LAST);
            if (acc) begin
                col <= col_nx;
                row <= row_nx;
                for (int unsigned i = 0; i < 3; i++) begin
                    w[i][0] <= w[i][1];
                    w[i][1] <= w[i][2];
                end
                w[0][2] <= lb1[c];
                w[1][2] <= lb0[c];
                w[2][2] <= bus.in_pixel;
                ox      <= c - X_ONE;
                oy      <= r - Y_ONE;
            end
        end
    end

    assign bus.out_valid = ov;
    assign bus.out_last  = ol;
    assign bus.out_x     = ox;
    assign bus.out_y     = oy;
    assign bus.p00 = w[0][0];
    assign bus.p01 = w[0][1];
    assign bus.p02 = w[0][2];
    assign bus.p10 = w[1][0];
    assign bus.p11 = w[1][1];
    assign bus.p12 = w[1][2];
    assign bus.p20 = w[2][0];
    assign bus.p21 = w[2][1];
    assign bus.p22 = w[2][2];
endmodule

// File: tb/tb_window_3x3_generator.sv
// Self-checking bench for window_3x3_generator on a 5x4 image (pixel = r*5 + c),
// using a cycle table for the plain frame and an image-array scoreboard for the rest.
module tb_window_3x3_generator;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic clk;
    logic rst_n;

    window_3x3_generator_if #(.DW(8), .XW(XW), .YW(YW)) bus ();

    window_3x3_generator #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [76:0] win;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0] pix;
        logic       ev;
        logic [7:0] e00, e11, e22;
        logic [2:0] ex;
        logic [1:0] ey;
        logic       el;
    } vec_t;

    exp_t        sb[$];
    logic [7:0]  img [H][W];
    int          mr, mc;
    int          checks, errors, wins;
    logic        prev_acc;
    logic [76:0] snap;
    logic [76:0] obs;

    assign obs = {bus.p00, bus.p01, bus.p02, bus.p10, bus.p11, bus.p12,
                  bus.p20, bus.p21, bus.p22, bus.out_x, bus.out_y};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: keep the frame as an array, form each window straight from it.
    task automatic send(input bit sof, input logic [7:0] val);
        int r, c;
        exp_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        r = mr;
        c = mc;
        img[r][c] = val;
        if (r >= 2 && c >= 2) begin
            e.win  = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                      img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                      img[r][c-2],   img[r][c-1],   img[r][c],
                      3'(c - 1), 2'(r - 1)};
            e.last = (r == H - 1) && (c == W - 1);
            sb.push_back(e);
        end
        mc = c + 1;
        if (mc == W) begin
            mc = 0;
            mr = (r == H - 1) ? 0 : r + 1;
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = val;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'($urandom);
            bus.in_pixel = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic frame(input int base, input bit gaps);
        for (int k = 0; k < W * H; k++) begin
            if (gaps)
                while ($urandom_range(99) < 40) idle(1);
            send(k == 0, 8'(base + k));
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_acc = 1'b0;
        else        prev_acc = bus.in_valid;
    end

    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            snap = '0;
        end else begin
            if (bus.out_valid) begin
                wins++;
                chk("valid_after_idle", 128'(prev_acc), 128'(1));
                if (sb.size() == 0) begin
                    chk("unexpected_window", 128'(obs), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("window", 128'({obs, bus.out_last}), 128'({e.win, e.last}));
                end
            end else begin
                chk("last_without_valid", 128'(bus.out_last), 128'(0));
                if (!prev_acc) chk("hold", 128'(obs), 128'(snap));
            end
            snap = obs;
        end
    end

    initial begin
        vec_t tv[W*H];
        int   w0;

        checks = 0;
        errors = 0;
        wins   = 0;
        mr     = 0;
        mc     = 0;
        for (int k = 0; k < W * H; k++) begin
            int r, c;
            r = k / W;
            c = k % W;
            tv[k].pix = 8'(k);
            tv[k].ev  = (r >= 2) && (c >= 2);
            tv[k].e00 = 8'((r - 2) * W + c - 2);
            tv[k].e11 = 8'((r - 1) * W + c - 1);
            tv[k].e22 = 8'(k);
            tv[k].ex  = 3'(c - 1);
            tv[k].ey  = 2'(r - 1);
            tv[k].el  = (k == W * H - 1);
        end

        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        rst_n        = 1'b0;
        #12;
        chk("reset_outputs", 128'({bus.out_valid, bus.out_last, obs}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Test 1: table-driven full frame, checked cycle by cycle.
        w0 = wins;
        for (int k = 0; k < W * H; k++) begin
            send(k == 0, tv[k].pix);
            if (tv[k].ev)
                chk($sformatf("t1_pix%0d", k),
                    128'({bus.out_valid, bus.out_last, bus.p00, bus.p11, bus.p22, bus.out_x, bus.out_y}),
                    128'({1'b1, tv[k].el, tv[k].e00, tv[k].e11, tv[k].e22, tv[k].ex, tv[k].ey}));
            else
                chk($sformatf("t1_pix%0d", k), 128'({bus.out_valid, bus.out_last}), 128'(0));
        end
        idle(2);
        chk("t1_count", 128'(wins - w0), 128'(6));

        // Test 2: random idle gaps.
        w0 = wins;
        frame(0, 1'b1);
        idle(2);
        chk("t2_count", 128'(wins - w0), 128'(6));

        // Test 3: back-to-back frames.
        w0 = wins;
        frame(0, 1'b0);
        frame(100, 1'b0);
        idle(2);
        chk("t3_count", 128'(wins - w0), 128'(12));

        // Test 4: partial frame abandoned by sof.
        w0 = wins;
        for (int k = 0; k < 8; k++) send(k == 0, 8'(k));
        frame(0, 1'b0);
        idle(2);
        chk("t4_count", 128'(wins - w0), 128'(6));

        // Test 5: asynchronous reset mid-frame.
        for (int k = 0; k < 13; k++) send(k == 0, 8'(k));
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", 128'({bus.out_valid, bus.out_last, obs}), 128'(0));
        sb.delete();
        mr = 0;
        mc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        w0 = wins;
        frame(0, 1'b0);
        idle(2);
        chk("t5_count", 128'(wins - w0), 128'(6));

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
